// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku grid validator.
// The optional conflict counter is enabled by defining SUDOKU_VALIDATOR_COUNT_EN.
package sudoku_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FIN} state_e;

    typedef enum logic [1:0] {PH_ROW, PH_COL, PH_BOX} phase_e;

    localparam int unsigned CELL_EMPTY = 0;

    // Width needed to index 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sudoku_cell_addr.sv
// Maps a scan position (phase, unit, idx) to a grid (row, col) for any box size.
module sudoku_cell_addr
    import sudoku_pkg::*;
#(
    parameter int unsigned BOX = 3,
    localparam int unsigned N  = BOX * BOX,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [1:0]    phase,
    input  logic [IW-1:0] unit,
    input  logic [IW-1:0] idx,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col
);

    int unsigned u;
    int unsigned i;
    int unsigned r;
    int unsigned c;

    always_comb begin
        u = 32'(unit);
        i = 32'(idx);
        r = u;
        c = i;
        case (phase_e'(phase))
            PH_ROW: begin
                r = u;
                c = i;
            end
            PH_COL: begin
                r = i;
                c = u;
            end
            PH_BOX: begin
                r = (u / BOX) * BOX + i / BOX;
                c = (u % BOX) * BOX + i % BOX;
            end
            default: begin
                r = u;
                c = i;
            end
        endcase
        row = IW'(r);
        col = IW'(c);
    end

endmodule

// File: rtl/sudoku_grid_validator.sv
// Sequential Sudoku checker: snapshots the grid, scans rows, columns, then boxes one cell per clock.
// Define SUDOKU_VALIDATOR_COUNT_EN to add conflict_cnt and disable the early exit on first conflict.
module sudoku_grid_validator
    import sudoku_pkg::*;
#(
    parameter int unsigned BOX   = 3,
    parameter int unsigned CW    = 4,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned N    = BOX * BOX,
    localparam int unsigned IW   = idx_width(N)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [N*N*CW-1:0] flat_grid,
    output logic              busy,
    output logic              done,
    output logic              solved,
    output logic              complete,
    output logic              conflict,
    output logic [IW-1:0]     conflict_row,
    output logic [IW-1:0]     conflict_col
`ifdef SUDOKU_VALIDATOR_COUNT_EN
    ,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    localparam int unsigned GW = N * N * CW;
    localparam int unsigned BW = idx_width(GW);
    localparam int unsigned SW = idx_width(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [CW-1:0] N_CW = CW'(N);

    state_e            state;
    phase_e            phase;
    logic [IW-1:0]     unit;
    logic [IW-1:0]     idx;
    logic [N-1:0]      seen;
    logic [GW-1:0]     grid_q;

    logic [IW-1:0]     row;
    logic [IW-1:0]     col;
    logic [BW-1:0]     cell_base;
    logic [CW-1:0]     v;
    logic [CW-1:0]     v_m1;
    logic              is_empty;
    logic              out_of_range;
    logic              dup;
    logic              cell_bad;
    logic              last_cell;
    logic              stop;

    sudoku_cell_addr #(
        .BOX(BOX)
    ) u_addr (
        .phase(phase),
        .unit (unit),
        .idx  (idx),
        .row  (row),
        .col  (col)
    );

    always_comb begin
        cell_base    = BW'((32'(row) * N + 32'(col)) * CW);
        v            = grid_q[cell_base +: CW];
        v_m1         = v - CW'(1);
        is_empty     = (v == CW'(CELL_EMPTY));
        out_of_range = (v > N_CW);
        dup          = !is_empty && !out_of_range && seen[SW'(v_m1)];
        cell_bad     = !is_empty && (out_of_range || dup);
        last_cell    = (phase == PH_BOX) && (unit == LAST) && (idx == LAST);
`ifdef SUDOKU_VALIDATOR_COUNT_EN
        stop         = last_cell;
`else
        stop         = last_cell || cell_bad;
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= ST_IDLE;
            phase        <= PH_ROW;
            unit         <= '0;
            idx          <= '0;
            seen         <= '0;
            grid_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            solved       <= 1'b0;
            complete     <= 1'b0;
            conflict     <= 1'b0;
            conflict_row <= '0;
            conflict_col <= '0;
`ifdef SUDOKU_VALIDATOR_COUNT_EN
            conflict_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The done cycle still belongs to the previous scan, so a start there is dropped.
                    if (start && !done) begin
                        grid_q       <= flat_grid;
                        phase        <= PH_ROW;
                        unit         <= '0;
                        idx          <= '0;
                        seen         <= '0;
                        busy         <= 1'b1;
                        solved       <= 1'b0;
                        complete     <= 1'b1;
                        conflict     <= 1'b0;
                        conflict_row <= '0;
                        conflict_col <= '0;
`ifdef SUDOKU_VALIDATOR_COUNT_EN
                        conflict_cnt <= '0;
`endif
                        state        <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (is_empty) begin
                        complete <= 1'b0;
                    end else if (cell_bad) begin
                        if (!conflict) begin
                            conflict     <= 1'b1;
                            conflict_row <= row;
                            conflict_col <= col;
                        end
`ifdef SUDOKU_VALIDATOR_COUNT_EN
                        if (conflict_cnt != '1) begin
                            conflict_cnt <= conflict_cnt + 1'b1;
                        end
`endif
                    end else begin
                        seen[SW'(v_m1)] <= 1'b1;
                    end

                    if (stop) begin
                        busy  <= 1'b0;
                        state <= ST_FIN;
                    end else if (idx == LAST) begin
                        // Later full-vector clear overrides the bit set above.
                        idx  <= '0;
                        seen <= '0;
                        if (unit == LAST) begin
                            unit  <= '0;
                            phase <= (phase == PH_ROW) ? PH_COL : PH_BOX;
                        end else begin
                            unit <= unit + 1'b1;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_FIN: begin
                    done   <= 1'b1;
                    solved <= complete & ~conflict;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
